// File: rtl/robertsons_pkg.sv
// +--------------------------------------------------------------------+
// | robertsons_pkg: shared types/constants for the Robertson controller |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package robertsons_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Matches the A:Q shift register mode input.
  localparam logic SHIFT_ARITH = 1'b0;
  localparam logic SHIFT_LOGIC = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage : robertsons_pkg

`default_nettype wire

// File: rtl/robertsons_controller_if.sv
// +--------------------------------------------------------------------+
// | robertsons_controller_if: controller <-> datapath/host signals     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface robertsons_controller_if
  import robertsons_pkg::*;
#(
  parameter int CNT_W = $clog2(DEFAULT_WIDTH)
) ();

  logic             start;
  logic             q0;
  logic             load;
  logic             add_en;
  logic             sub;
  logic             shift_en;
  logic             shift_mode;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter;

  modport master (
    input  start, q0,
    output load, add_en, sub, shift_en, shift_mode, busy, done, iter
  );

  modport slave (
    output start, q0,
    input  load, add_en, sub, shift_en, shift_mode, busy, done, iter
  );

endinterface : robertsons_controller_if

`default_nettype wire

// File: rtl/robertsons_controller_iteration_counter.sv
// +--------------------------------------------------------------------+
// | robertsons_controller_iteration_counter: loadable down-counter     |
// | that saturates at zero and flags it.            Rev 1.0            |
// +--------------------------------------------------------------------+
`default_nettype none

module robertsons_controller_iteration_counter #(
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic             i_dec,
  input  wire logic [CNT_W-1:0] i_load_val,
  output      logic [CNT_W-1:0] o_count,
  output      logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule : robertsons_controller_iteration_counter

`default_nettype wire

// File: rtl/robertsons_controller.sv
// +--------------------------------------------------------------------+
// | robertsons_controller: sequences the Robertson signed multiplier   |
// | datapath (load, add/sub-or-skip, arithmetic shift). Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module robertsons_controller
  import robertsons_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input wire logic              clk,
  input wire logic              rst_n,
  robertsons_controller_if.master bus
);

  localparam logic [CNT_W-1:0] c_iter_last = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic             r_load;
  logic             r_add_en;
  logic             r_sub;
  logic             r_shift_en;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_iter;
  logic             w_iter_zero;
  logic             w_cnt_load;
  logic             w_cnt_dec;

  assign w_cnt_load = (r_state == LOAD);
  assign w_cnt_dec  = (r_state == SHIFT);

  robertsons_controller_iteration_counter #(
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (c_iter_last),
    .o_count    (w_iter),
    .o_zero     (w_iter_zero)
  );

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_load     <= 1'b0;
      r_add_en   <= 1'b0;
      r_sub      <= 1'b0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_load     <= 1'b0;
      r_add_en   <= 1'b0;
      r_sub      <= 1'b0;
      r_shift_en <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= LOAD;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          r_state <= TEST;
        end
        TEST: begin
          if (bus.q0) begin
            r_state  <= ADD;
            r_add_en <= 1'b1;
            // Last iteration weighs the multiplier sign bit negatively.
            r_sub    <= w_iter_zero;
          end else begin
            r_state    <= SHIFT;
            r_shift_en <= 1'b1;
          end
        end
        ADD: begin
          r_state    <= SHIFT;
          r_shift_en <= 1'b1;
        end
        SHIFT: begin
          if (w_iter_zero) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= TEST;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load       = r_load;
  assign bus.add_en     = r_add_en;
  assign bus.sub        = r_sub;
  assign bus.shift_en   = r_shift_en;
  assign bus.shift_mode = SHIFT_ARITH;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.iter       = w_iter;

endmodule : robertsons_controller

`default_nettype wire

// File: tb/tb_robertsons_controller.sv
// +--------------------------------------------------------------------+
// | tb_robertsons_controller: controller + behavioural A:Q datapath,   |
// | products and cycle counts checked against arithmetic. Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_robertsons_controller;
  import robertsons_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int OP_CYC = 2 * WIDTH + 3;  // load-to-load period with start held

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  robertsons_controller_if #(.CNT_W(CNT_W)) bus ();

  robertsons_controller #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Datapath model: A is one bit wider so A +/- M never overflows before the shift.
  logic signed [WIDTH:0]   dp_a = '0;
  logic        [WIDTH-1:0] dp_q = '0;
  logic        [WIDTH-1:0] dp_m = '0;
  logic        [WIDTH-1:0] mplier = '0;

  assign bus.q0 = dp_q[0];

  always @(posedge clk) begin
    if (bus.load) begin
      dp_a <= '0;
      dp_q <= mplier;
    end else if (bus.add_en) begin
      if (bus.sub) dp_a <= dp_a - {dp_m[WIDTH-1], dp_m};
      else         dp_a <= dp_a + {dp_m[WIDTH-1], dp_m};
    end else if (bus.shift_en) begin
      if (bus.shift_mode) {dp_a, dp_q} <= {dp_a, dp_q} >> 1;
      else                {dp_a, dp_q} <= $signed({dp_a, dp_q}) >>> 1;
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] mp, input logic [WIDTH-1:0] mc, input string tag);
    int n_load = 0, n_add = 0, n_shift = 0, n_sub = 0, n_bad = 0;
    int first_it = -1, last_it = -1, done_cyc = -1;
    int pop, lo, hi;
    longint prod;
    logic [63:0] prod_v;
    mplier = mp;
    dp_m   = mc;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int c = 1; c <= 4 * WIDTH && done_cyc < 0; c++) begin
      @(negedge clk);
      if ((int'(bus.load) + int'(bus.add_en) + int'(bus.shift_en)) > 1) n_bad++;
      if (bus.sub && !bus.add_en) n_bad++;
      if (bus.shift_mode != SHIFT_ARITH) n_bad++;
      if (!bus.busy) n_bad++;
      if (bus.load) n_load++;
      if (bus.shift_en) n_shift++;
      if (bus.add_en) begin
        n_add++;
        if (first_it < 0) first_it = int'(bus.iter);
        last_it = int'(bus.iter);
        if (bus.sub != (bus.iter == '0)) n_bad++;
        if (bus.sub) n_sub++;
      end
      if (bus.done) done_cyc = c;
    end
    @(negedge clk);
    check_eq({tag, "_busy_after"}, {63'd0, bus.busy}, 64'd0);

    pop = $countones(mp);
    lo = -1; hi = -1;
    for (int b = 0; b < WIDTH; b++) if (mp[b]) begin if (lo < 0) lo = b; hi = b; end
    prod   = longint'($signed(mp)) * longint'($signed(mc));
    prod_v = 64'(prod);
    check_eq({tag, "_product"}, 64'({dp_a[WIDTH-1:0], dp_q}), 64'(prod_v[2*WIDTH-1:0]));
    check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'(2 * WIDTH + 2 + pop));
    check_eq({tag, "_loads"}, 64'(n_load), 64'd1);
    check_eq({tag, "_adds"}, 64'(n_add), 64'(pop));
    check_eq({tag, "_shifts"}, 64'(n_shift), 64'(WIDTH));
    check_eq({tag, "_subs"}, 64'(n_sub), 64'(mp[WIDTH-1]));
    check_eq({tag, "_rule_viol"}, 64'(n_bad), 64'd0);
    if (pop > 0) begin
      check_eq({tag, "_first_add_iter"}, 64'(first_it), 64'(WIDTH - 1 - lo));
      check_eq({tag, "_last_add_iter"}, 64'(last_it), 64'(WIDTH - 1 - hi));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", 64'({bus.load, bus.add_en, bus.sub, bus.shift_en, bus.busy, bus.done}), 64'd0);
    check_eq("reset_iter", 64'(bus.iter), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_after_reset", 64'({bus.load, bus.busy, bus.done}), 64'd0);

    run_op(16'h0000, 16'h1234, "mp0000");
    run_op(16'h0001, 16'h7FFF, "mp0001");
    run_op(16'h8000, 16'h0003, "mp8000");
    check_eq("mp8000_literal", 64'({dp_a[WIDTH-1:0], dp_q}), 64'h0000_0000_FFFE_8000);
    run_op(16'hFFFF, 16'h0005, "mpFFFF");
    check_eq("mpFFFF_literal", 64'({dp_a[WIDTH-1:0], dp_q}), 64'h0000_0000_FFFF_FFFB);
    run_op(16'h8000, 16'h8000, "mp_minmin");
    for (int k = 0; k < 10; k++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), $sformatf("rnd%0d", k));
    end

    // Asynchronous reset while an ADD cycle is in progress.
    begin
      bit seen = 1'b0;
      mplier = 16'hFFFF;
      dp_m   = 16'h0011;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (bus.add_en) seen = 1'b1;
      end
      check_eq("rst_saw_add", 64'(seen), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_mid_outputs", 64'({bus.load, bus.add_en, bus.sub, bus.shift_en, bus.busy, bus.done}), 64'd0);
      check_eq("rst_mid_iter", 64'(bus.iter), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_release_idle", 64'({bus.load, bus.add_en, bus.shift_en, bus.busy, bus.done}), 64'd0);
      check_eq("rst_release_iter", 64'(bus.iter), 64'd0);
    end

    // Start held high: ignored while busy, re-launches two cycles after each done.
    begin
      int loads = 0, dones = 0, last_load = 0;
      mplier = '0;
      dp_m   = '0;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 120; c++) begin
        @(negedge clk);
        if (bus.load) begin
          check_eq("held_load_cyc", 64'(c), 64'(1 + loads * OP_CYC));
          last_load = c;
          loads++;
        end
        if (bus.done) begin
          check_eq("held_done_cyc", 64'(c), 64'(last_load + 2 * WIDTH + 1));
          dones++;
        end
      end
      check_eq("held_loads", 64'(loads), 64'((120 - 1) / OP_CYC + 1));
      check_eq("held_dones", 64'(dones), 64'((120 - 1 - (2 * WIDTH + 1)) / OP_CYC + 1));
      bus.start = 1'b0;
      begin
        bit idle = 1'b0;
        for (int c = 0; c < 4 * WIDTH && !idle; c++) begin
          @(negedge clk);
          if (!bus.busy) idle = 1'b1;
        end
        check_eq("held_return_idle", 64'(idle), 64'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_robertsons_controller

`default_nettype wire
